exc_vector_fetch: RTL and testbench

Exception front-end of the multicycle CPU. On an exception it saves EPC, reads the handler-address byte from the fixed vector location in memory, and presents that byte on byte_out. byte_out drives the 8-bit zero-extend input of the 16/8-to-32 extender, whose output becomes the new PC. It sits between the control unit and exception sources (upstream) and the memory and extender (downstream).

---
 rtl/exc_vector_fetch.sv | 131 +++++++++++++
 tb/tb_exc_vector_fetch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_vector_fetch.sv
// Exception vector fetch: saves EPC, reads the handler byte from the fixed vector slot,
// and holds it on byte_out for the extender until the control unit acknowledges it.
module exc_vector_fetch #(
   parameter int unsigned MEM_LATENCY = 1,
   parameter logic [7:0]  ADDR_OPCODE = 8'd253,
   parameter logic [7:0]  ADDR_OVF    = 8'd254,
   parameter logic [7:0]  ADDR_DIV0   = 8'd255,
   parameter logic [31:0] PC_OFFSET   = 32'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        exc_opcode,
   input  logic        exc_ovf,
   input  logic        exc_div0,
   input  logic [31:0] pc_in,
   input  logic [31:0] mem_data_in,
   input  logic        vec_ack,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   output logic [31:0] epc_out,
   output logic        epc_we,
   output logic [1:0]  exc_cause,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   output logic        busy,
   output logic        exc_lost
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SAVE = 2'd1;
   localparam logic [1:0] READ = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q;
   logic [31:0] mem_addr_q;
   logic [31:0] epc_q;
   logic [1:0]  cause_q;
   logic [1:0]  cause_new;
   logic [7:0]  byte_q;
   logic        lost_q;
   logic        exc_any;
   logic [7:0]  vec_addr;

   assign exc_any = exc_opcode | exc_ovf | exc_div0;

   always_comb begin
      cause_new = 2'b11;
      if (exc_opcode) begin
         cause_new = 2'b01;
      end else if (exc_ovf) begin
         cause_new = 2'b10;
      end
   end

   always_comb begin
      vec_addr = ADDR_DIV0;
      case (cause_q)
         2'b01:   vec_addr = ADDR_OPCODE;
         2'b10:   vec_addr = ADDR_OVF;
         default: vec_addr = ADDR_DIV0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (exc_any) state_d = SAVE;
         SAVE: state_d = READ;
         READ: if (cnt_q == 4'd0) state_d = DONE;
         DONE: if (vec_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         mem_addr_q <= 32'd0;
         epc_q      <= 32'd0;
         cause_q    <= 2'b00;
         byte_q     <= 8'd0;
         lost_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         // Any request seen outside IDLE is dropped; remember that it happened.
         if ((state_q != IDLE) && exc_any) begin
            lost_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (exc_any) begin
                  cause_q <= cause_new;
                  epc_q   <= pc_in - PC_OFFSET;
               end
            end
            SAVE: begin
               mem_addr_q <= {24'd0, vec_addr};
               cnt_q      <= LAT_M1;
            end
            READ: begin
               if (cnt_q == 4'd0) begin
                  byte_q <= mem_data_in[7:0];
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            DONE: begin
               if (vec_ack) begin
                  mem_addr_q <= 32'd0;
               end
            end
            default: ;
         endcase
      end
   end

   assign epc_we     = (state_q == SAVE);
   assign mem_rd     = (state_q == READ);
   assign byte_valid = (state_q == DONE);
   assign busy       = (state_q != IDLE);
   assign mem_addr   = mem_addr_q;
   assign epc_out    = epc_q;
   assign exc_cause  = cause_q;
   assign byte_out   = byte_q;
   assign exc_lost   = lost_q;

endmodule

// File: tb/tb_exc_vector_fetch.sv
// Bench for exc_vector_fetch: two instances (latency 1 and 3) share stimulus; one is observed.
module tb_exc_vector_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        exc_opcode = 1'b0, exc_ovf = 1'b0, exc_div0 = 1'b0;
   logic [31:0] pc_in = 32'd0;
   logic        vec_ack = 1'b0;
   logic        sel = 1'b0;
   logic [7:0]  mem [256];

   logic [31:0] a1, a3, e1, e3, md1, md3;
   logic        rd1, rd3, we1, we3, bv1, bv3, by1, by3, lo1, lo3;
   logic [1:0]  c1, c3;
   logic [7:0]  b1, b3;

   logic [31:0] mem_addr, epc_out;
   logic        mem_rd, epc_we, byte_valid, busy, exc_lost;
   logic [1:0]  exc_cause;
   logic [7:0]  byte_out;

   int total = 0;
   int bad = 0;
   bit exp_lost = 1'b0;
   bit pend = 1'b0;

   always #5 clk = ~clk;

   assign md1 = {24'hdeadbe, mem[a1[7:0]]};
   assign md3 = {24'hc0ffee, mem[a3[7:0]]};

   exc_vector_fetch #(.MEM_LATENCY(1)) u_l1 (
      .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf),
      .exc_div0(exc_div0), .pc_in(pc_in), .mem_data_in(md1), .vec_ack(vec_ack),
      .mem_addr(a1), .mem_rd(rd1), .epc_out(e1), .epc_we(we1), .exc_cause(c1),
      .byte_out(b1), .byte_valid(bv1), .busy(by1), .exc_lost(lo1)
   );

   exc_vector_fetch #(.MEM_LATENCY(3)) u_l3 (
      .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf),
      .exc_div0(exc_div0), .pc_in(pc_in), .mem_data_in(md3), .vec_ack(vec_ack),
      .mem_addr(a3), .mem_rd(rd3), .epc_out(e3), .epc_we(we3), .exc_cause(c3),
      .byte_out(b3), .byte_valid(bv3), .busy(by3), .exc_lost(lo3)
   );

   always_comb begin
      mem_addr   = sel ? a3  : a1;
      mem_rd     = sel ? rd3 : rd1;
      epc_out    = sel ? e3  : e1;
      epc_we     = sel ? we3 : we1;
      exc_cause  = sel ? c3  : c1;
      byte_out   = sel ? b3  : b1;
      byte_valid = sel ? bv3 : bv1;
      busy       = sel ? by3 : by1;
      exc_lost   = sel ? lo3 : lo1;
   end

   typedef struct {
      logic [2:0]  exc;   // {opcode, ovf, div0}
      logic [31:0] pc;
      logic [1:0]  cause;
      logic [7:0]  addr;
      logic [31:0] epc;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one edge; outputs are looked at 1 time unit later.
   task automatic adv();
      @(posedge clk);
      #1;
      if (pend) begin
         exp_lost = 1'b1;
         pend     = 1'b0;
         exc_ovf  = 1'b0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      exp_lost = 1'b0;
      repeat (2) adv();
      reset = 1'b1;
   endtask

   // One full exception: sample, SAVE, L READ cycles, DONE held ack_delay cycles, ack.
   task automatic run_txn(input logic [2:0] exc, input logic [31:0] pc,
                          input logic [1:0] ecause, input logic [7:0] eaddr,
                          input logic [31:0] eepc, input int ack_delay,
                          input bit pulse, input bit chain);
      int          lat;
      logic [7:0]  eb;
      lat = sel ? 3 : 1;
      eb  = mem[eaddr];
      {exc_opcode, exc_ovf, exc_div0} = exc;
      pc_in = pc;
      adv();
      {exc_opcode, exc_ovf, exc_div0} = 3'b000;
      pc_in = $urandom;
      chk("save_we", {31'd0, epc_we}, 32'd1);
      chk("save_rd", {31'd0, mem_rd}, 32'd0);
      chk("save_epc", epc_out, eepc);
      chk("save_cause", {30'd0, exc_cause}, {30'd0, ecause});
      chk("save_busy", {31'd0, busy}, 32'd1);
      for (int k = 0; k < lat; k++) begin
         adv();
         chk("read_rd", {31'd0, mem_rd}, 32'd1);
         chk("read_addr", mem_addr, {24'd0, eaddr});
         chk("read_we", {31'd0, epc_we}, 32'd0);
         chk("read_bv", {31'd0, byte_valid}, 32'd0);
         chk("read_lost", {31'd0, exc_lost}, {31'd0, exp_lost});
         if (pulse && k == 0) begin
            exc_ovf = 1'b1;
            pend    = 1'b1;
         end
      end
      adv();
      chk("done_bv", {31'd0, byte_valid}, 32'd1);
      chk("done_byte", {24'd0, byte_out}, {24'd0, eb});
      chk("done_rd", {31'd0, mem_rd}, 32'd0);
      chk("done_addr", mem_addr, {24'd0, eaddr});
      chk("done_cause", {30'd0, exc_cause}, {30'd0, ecause});
      chk("done_lost", {31'd0, exc_lost}, {31'd0, exp_lost});
      for (int d = 0; d < ack_delay; d++) begin
         adv();
         chk("hold_bv", {31'd0, byte_valid}, 32'd1);
         chk("hold_byte", {24'd0, byte_out}, {24'd0, eb});
      end
      vec_ack = 1'b1;
      if (chain) begin
         exc_ovf = 1'b1;
      end
      adv();
      vec_ack = 1'b0;
      if (chain) begin
         exp_lost = 1'b1;
      end
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_bv", {31'd0, byte_valid}, 32'd0);
      chk("idle_addr", mem_addr, 32'd0);
      chk("idle_byte", {24'd0, byte_out}, {24'd0, eb});
      chk("idle_epc", epc_out, eepc);
      chk("idle_cause", {30'd0, exc_cause}, {30'd0, ecause});
      chk("idle_lost", {31'd0, exc_lost}, {31'd0, exp_lost});
   endtask

   // Reference: priority opcode > ovf > div0, vector slots 253/254/255, EPC = pc - 4.
   function automatic logic [1:0] model_cause(input logic [2:0] exc);
      if (exc[2]) return 2'd1;
      if (exc[1]) return 2'd2;
      return 2'd3;
   endfunction

   vec_t tbl[6];

   initial begin
      tbl[0] = '{exc: 3'b010, pc: 32'h0000_0044, cause: 2'd2, addr: 8'd254, epc: 32'h0000_0040};
      tbl[1] = '{exc: 3'b101, pc: 32'h0000_0000, cause: 2'd1, addr: 8'd253, epc: 32'hFFFF_FFFC};
      tbl[2] = '{exc: 3'b001, pc: 32'h1234_5678, cause: 2'd3, addr: 8'd255, epc: 32'h1234_5674};
      tbl[3] = '{exc: 3'b011, pc: 32'h0000_0004, cause: 2'd2, addr: 8'd254, epc: 32'h0000_0000};
      tbl[4] = '{exc: 3'b111, pc: 32'h0000_0002, cause: 2'd1, addr: 8'd253, epc: 32'hFFFF_FFFE};
      tbl[5] = '{exc: 3'b100, pc: 32'hFFFF_FFFF, cause: 2'd1, addr: 8'd253, epc: 32'hFFFF_FFFB};
      for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5a);
      mem[253] = 8'h91;
      mem[254] = 8'h3C;
      mem[255] = 8'hA7;

      do_reset();
      // Quiet idle after reset
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_epc", epc_out, 32'd0);
      chk("rst_byte", {24'd0, byte_out}, 32'd0);
      chk("rst_cause", {30'd0, exc_cause}, 32'd0);
      chk("rst_lost", {31'd0, exc_lost}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         adv();
         chk("idle_strobes", {28'd0, mem_rd, epc_we, busy, byte_valid}, 32'd0);
      end

      // Table vectors on latency 1
      for (int i = 0; i < 6; i++) begin
         run_txn(tbl[i].exc, tbl[i].pc, tbl[i].cause, tbl[i].addr, tbl[i].epc, i % 3, 1'b0, 1'b0);
      end
      chk("tbl_lost", {31'd0, exc_lost}, 32'd0);

      // Latency 3, div0, byte_valid held 5 cycles before ack
      sel = 1'b1;
      do_reset();
      run_txn(3'b001, 32'h0000_1000, 2'd3, 8'd255, 32'h0000_0FFC, 4, 1'b0, 1'b0);

      // Ovf pulsed during READ is ignored and sets exc_lost, which survives ack
      run_txn(3'b010, 32'h0000_2000, 2'd2, 8'd254, 32'h0000_1FFC, 1, 1'b1, 1'b0);
      adv();
      chk("lost_sticky", {31'd0, exc_lost}, 32'd1);
      chk("lost_nobusy", {31'd0, busy}, 32'd0);

      // Ack with a new request in DONE: back to IDLE first, then taken next edge
      run_txn(3'b001, 32'h0000_3000, 2'd3, 8'd255, 32'h0000_2FFC, 0, 1'b0, 1'b1);
      run_txn(3'b010, 32'h0000_4000, 2'd2, 8'd254, 32'h0000_3FFC, 0, 1'b0, 1'b0);

      // Reset during READ aborts immediately
      exc_div0 = 1'b1;
      pc_in = 32'h0000_5000;
      adv();
      exc_div0 = 1'b0;
      adv();
      chk("pre_abort_rd", {31'd0, mem_rd}, 32'd1);
      reset = 1'b0;
      exp_lost = 1'b0;
      #1;
      chk("abort_rd", {31'd0, mem_rd}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_addr", mem_addr, 32'd0);
      chk("abort_epc", epc_out, 32'd0);
      chk("abort_byte", {24'd0, byte_out}, 32'd0);
      chk("abort_cause", {30'd0, exc_cause}, 32'd0);
      chk("abort_lost", {31'd0, exc_lost}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         adv();
         chk("abort_quiet", {30'd0, mem_rd, epc_we}, 32'd0);
      end
      reset = 1'b1;
      adv();
      run_txn(3'b100, 32'h0000_6000, 2'd1, 8'd253, 32'h0000_5FFC, 1, 1'b0, 1'b0);

      // Randomized transactions against the reference model
      for (int n = 0; n < 60; n++) begin
         logic [2:0]  ex;
         logic [31:0] pc;
         logic [1:0]  ca;
         logic        ns;
         ns = 1'($urandom_range(0, 1));
         if (ns != sel) begin
            sel = ns;
            do_reset();
         end
         mem[253] = 8'($urandom);
         mem[254] = 8'($urandom);
         mem[255] = 8'($urandom);
         ex = 3'($urandom_range(1, 7));
         pc = $urandom;
         ca = model_cause(ex);
         run_txn(ex, pc, ca, 8'd252 + {6'd0, ca}, pc - 32'd4, $urandom_range(0, 4),
                 ($urandom_range(0, 3) == 0), 1'b0);
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            adv();
            chk("gap_busy", {31'd0, busy}, 32'd0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
